// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the segmented, pipelined add/subtract unit.
package pipe_adder_pkg;

  // Operation select carried alongside each operand beat.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Bits resolved per pipeline stage.
  function automatic int seg_count(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// Combinational ripple segment: per-bit generate/propagate with a carry chain,
// reporting the carry out and the carry entering the segment's top bit.
module adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_c_msb
);

  logic [SEG-1:0] w_p;
  logic [SEG-1:0] w_g;

  for (genvar gi = 0; gi < SEG; gi++) begin : g_pg
    assign w_p[gi] = i_a[gi] ^ i_b[gi];
    assign w_g[gi] = i_a[gi] & i_b[gi];
  end

  // Ripple the carry through the segment; the last carry seen before the top
  // bit is the carry into the MSB, used for signed overflow.
  always_comb begin
    logic w_carry;
    w_carry = i_cin;
    o_sum   = '0;
    o_c_msb = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      o_c_msb  = w_carry;
      o_sum[i] = w_p[i] ^ w_carry;
      w_carry  = w_g[i] | (w_p[i] & w_carry);
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one SEG-bit segment resolved per stage, carry held
// in a register between stages, valid/ready handshake with full backpressure.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_e              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_count(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_width_check
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end

  // Subtraction is a + ~b + 1; the incoming cin only matters for ADD.
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  assign w_b_eff   = (op == OP_SUB) ? ~b : b;
  assign w_cin_eff = (op == OP_SUB) ? 1'b1 : cin;

  // w_adv[k]: stage k loads this cycle. An empty stage always loads, so
  // bubbles collapse; a full stage loads only when its successor moves.
  logic [STAGES:0] w_adv;
  assign w_adv[STAGES] = out_ready;
  assign in_ready      = w_adv[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int SUMW = SEG * (gi + 1);
    localparam int REM  = WIDTH - SUMW;

    logic            r_valid;
    logic [SUMW-1:0] r_sum;
    logic            r_carry;

    logic            w_prev_valid;
    logic [SEG-1:0]  w_seg_a;
    logic [SEG-1:0]  w_seg_b;
    logic [SEG-1:0]  w_seg_sum;
    logic            w_seg_cin;
    logic            w_seg_cout;
    logic            w_seg_c_msb;
    logic [SUMW-1:0] w_sum_in;

    if (gi == 0) begin : g_src
      assign w_prev_valid = in_valid;
      assign w_seg_a      = a[SEG-1:0];
      assign w_seg_b      = w_b_eff[SEG-1:0];
      assign w_seg_cin    = w_cin_eff;
      assign w_sum_in     = w_seg_sum;
    end else begin : g_src
      assign w_prev_valid = g_stage[gi-1].r_valid;
      assign w_seg_a      = g_stage[gi-1].g_rem.r_a_rem[SEG-1:0];
      assign w_seg_b      = g_stage[gi-1].g_rem.r_b_rem[SEG-1:0];
      assign w_seg_cin    = g_stage[gi-1].r_carry;
      assign w_sum_in     = {w_seg_sum, g_stage[gi-1].r_sum};
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .i_a    (w_seg_a),
      .i_b    (w_seg_b),
      .i_cin  (w_seg_cin),
      .o_sum  (w_seg_sum),
      .o_cout (w_seg_cout),
      .o_c_msb(w_seg_c_msb)
    );

    assign w_adv[gi] = !r_valid || w_adv[gi+1];

    // Stage valid, resolved low sum bits and forwarded carry; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_sum   <= '0;
        r_carry <= 1'b0;
      end else if (w_adv[gi]) begin
        r_valid <= w_prev_valid;
        r_sum   <= w_sum_in;
        r_carry <= w_seg_cout;
      end
    end

    // Operand bits not yet resolved, shifted down so the next segment is at bit 0.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] r_a_rem;
      logic [REM-1:0] r_b_rem;
      logic [REM-1:0] w_a_rem_in;
      logic [REM-1:0] w_b_rem_in;

      if (gi == 0) begin : g_rem_src
        assign w_a_rem_in = a[WIDTH-1:SEG];
        assign w_b_rem_in = w_b_eff[WIDTH-1:SEG];
      end else begin : g_rem_src
        assign w_a_rem_in = g_stage[gi-1].g_rem.r_a_rem[SEG +: REM];
        assign w_b_rem_in = g_stage[gi-1].g_rem.r_b_rem[SEG +: REM];
      end

      // Carry the remaining operand bits forward with the beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a_rem <= '0;
          r_b_rem <= '0;
        end else if (w_adv[gi]) begin
          r_a_rem <= w_a_rem_in;
          r_b_rem <= w_b_rem_in;
        end
      end
    end

    if (gi == STAGES - 1) begin : g_out
      logic r_c_msb;

      // Carry into the result MSB, only known once the top segment resolves.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_c_msb <= 1'b0;
        end else if (w_adv[gi]) begin
          r_c_msb <= w_seg_c_msb;
        end
      end

      assign out_valid = r_valid;
      assign sum       = r_sum;
      assign cout      = r_carry;
      assign ovf       = r_c_msb ^ r_carry;
    end else begin : g_mid
      logic w_unused_c_msb;
      assign w_unused_c_msb = w_seg_c_msb;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench: three configurations (8/2, 32/4, 32/1) run in parallel,
// each driven by directed then random traffic and scored against an
// arithmetic model of the add/subtract and an occupancy model of the pipe.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  typedef struct {
    logic [33:0] res;   // {ovf, cout, sum[31:0]}
    int          t;     // posedge index at which the beat was accepted
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic; signed overflow from operand/result sign rule.
  function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                        input logic [31:0] bv, input logic c,
                                        input logic sub);
    logic [63:0] mask, aa, bb, full, s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, av} & mask;
    bb   = sub ? (~{32'd0, bv}) & mask : {32'd0, bv} & mask;
    full = aa + bb + (sub ? 64'd1 : {63'd0, c});
    s    = full & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s[31:0]};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 8 : 32;
    localparam int S = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

    logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    op_e          op;
    ent_t         q[$];
    int           cycle;
    int           n_acc;
    int           acc_win;
    bit           done_g = 1'b0;

    pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .op       (op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf)
    );

    // One clock: check outputs, drive inputs, check in_ready, update model.
    task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic c, input op_e o, input logic ordy);
      logic exp_ov, exp_ir;
      ent_t e;
      exp_ov = (q.size() > 0) && (cycle - q[0].t >= S - 1);
      check($sformatf("cfg%0d out_valid", gi), 64'(out_valid), 64'(exp_ov));
      if (exp_ov && out_valid)
        check($sformatf("cfg%0d result", gi), 64'({ovf, cout, 32'(sum)}), 64'(q[0].res));
      in_valid  = v;
      a         = av;
      b         = bv;
      cin       = c;
      op        = o;
      out_ready = ordy;
      #1;
      exp_ir = ordy || (q.size() < S);
      check($sformatf("cfg%0d in_ready", gi), 64'(in_ready), 64'(exp_ir));
      if (v && in_ready) acc_win++;
      if (exp_ov && ordy) void'(q.pop_front());
      if (v && exp_ir) begin
        e.res = model(W, 32'(av), 32'(bv), c, o == OP_SUB);
        e.t   = cycle + 1;
        q.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      cycle++;
      @(negedge clk);
    endtask

    task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check($sformatf("cfg%0d rst out_valid", gi), 64'(out_valid), 64'd0);
      check($sformatf("cfg%0d rst result", gi), 64'({ovf, cout, 32'(sum)}), 64'd0);
      check($sformatf("cfg%0d rst in_ready", gi), 64'(in_ready), 64'd1);
      q.delete();
      @(posedge clk);
      cycle++;
      @(negedge clk);
      rst_n = 1'b1;
    endtask

    initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; op = OP_ADD;
      cycle = 0; n_acc = 0; acc_win = 0;
      #2;
      do_reset();

      // Directed: overflow add, subtract with borrow (cin ignored), MIN-1, carry across segments.
      step(1'b1, MAXP, W'(1), 1'b0, OP_ADD, 1'b1);
      step(1'b1, W'(5), W'(7), 1'b1, OP_SUB, 1'b1);
      step(1'b1, MINN, W'(1), 1'b0, OP_SUB, 1'b1);
      step(1'b1, '1, '0, 1'b1, OP_ADD, 1'b1);
      repeat (S + 2) step(1'b0, '0, '0, 1'b0, OP_ADD, 1'b1);

      // Backpressure: stream in with the consumer stalled.
      acc_win = 0;
      repeat (5) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), OP_ADD, 1'b0);
      check($sformatf("cfg%0d bp_accepted", gi), 64'(acc_win), 64'(S));
      repeat (S + 2) step(1'b0, '0, '0, 1'b0, OP_ADD, 1'b1);
      check($sformatf("cfg%0d bp_drained", gi), 64'(q.size()), 64'd0);

      // Reset with beats in flight; nothing stale may appear afterwards.
      step(1'b1, W'($urandom), W'($urandom), 1'b0, OP_ADD, 1'b0);
      step(1'b1, W'($urandom), W'($urandom), 1'b0, OP_SUB, 1'b0);
      do_reset();
      repeat (S + 3) step(1'b0, '0, '0, 1'b0, OP_ADD, 1'b1);

      // Random traffic with random stalls on both sides.
      n_acc = 0;
      for (int k = 0; k < 40000 && n_acc < 10000; k++)
        step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom),
             op_e'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      check($sformatf("cfg%0d random_beats", gi), 64'(n_acc >= 10000), 64'd1);
      repeat (S + 2) step(1'b0, '0, '0, 1'b0, OP_ADD, 1'b1);
      check($sformatf("cfg%0d random_drained", gi), 64'(q.size()), 64'd0);
      done_g = 1'b1;
    end
  end

  initial begin
    // Hand-computed expectations pinning the model.
    check("pin add 7F+01", 64'(model(8, 32'h7F, 32'h01, 1'b0, 1'b0)), 64'h2_0000_0080);
    check("pin sub 05-07", 64'(model(8, 32'h05, 32'h07, 1'b1, 1'b1)), 64'h0_0000_00FE);
    check("pin sub 80-01", 64'(model(8, 32'h80, 32'h01, 1'b0, 1'b1)), 64'h3_0000_007F);
    check("pin add FF+00+1", 64'(model(8, 32'hFF, 32'h00, 1'b1, 1'b0)), 64'h1_0000_0000);
    check("pin add32 max+1", 64'(model(32, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'h2_8000_0000);
    check("pin add32 ones+cin", 64'(model(32, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0)), 64'h1_0000_0000);

    for (int i = 0; i < 90000 && !(g_cfg[0].done_g && g_cfg[1].done_g && g_cfg[2].done_g); i++)
      @(posedge clk);
    check("all_configs_done",
          64'({g_cfg[2].done_g, g_cfg[1].done_g, g_cfg[0].done_g}), 64'h7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
